mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported main memory between instruction fetch and the data memory controller. Both sides use the same level-request / single-cycle-ready handshake: word address, per-byte write enables, and a read enable. The arbiter latches the winning request into registered memory-side strobes and returns the memory's ready pulse and read data to the granted requester only. A watchdog aborts any access the memory never acknowledges.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: data-side and instruction-side requester
// handshakes plus the registered memory-side strobes.
interface mem_port_arbiter_if;
    logic        d_read;
    logic [3:0]  d_write;
    logic [29:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;

    logic        i_read;
    logic [29:0] i_address;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_error;

    logic [29:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Arbiter side
    modport slave (
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_ready, d_error,
        input  i_read, i_address,
        output i_rdata, i_ready, i_error,
        output mem_address, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_ack
    );

    // Requesters and memory model side
    modport master (
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_ready, d_error,
        output i_read, i_address,
        input  i_rdata, i_ready, i_error,
        input  mem_address, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the data controller, with a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;
    typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

    state_t           state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      mem_address_q, mem_address_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;

    logic d_req, i_req, timeout, done, d_sel, i_sel;

    assign d_req   = bus.d_read | (bus.d_write != 4'b0000);
    assign i_req   = bus.i_read;
    // An ack in the timeout cycle wins, so timeout only counts without ack
    assign timeout = (cnt_q == CNT_LAST) & ~bus.mem_ack;
    assign done    = bus.mem_ack | timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_I;
            cnt_q         <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= '0;
            mem_re_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        mem_re_d      = mem_re_q;

        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || last_grant_q == GRANT_I)) begin
                    state_d       = D_BUSY;
                    last_grant_d  = GRANT_D;
                    cnt_d         = '0;
                    mem_address_d = bus.d_address;
                    if (bus.d_write != 4'b0000) begin
                        mem_we_d    = bus.d_write;
                        mem_wdata_d = bus.d_wdata;
                        mem_re_d    = 1'b0;
                    end else begin
                        mem_we_d    = 4'b0000;
                        mem_re_d    = 1'b1;
                    end
                end else if (i_req) begin
                    state_d       = I_BUSY;
                    last_grant_d  = GRANT_I;
                    cnt_d         = '0;
                    mem_address_d = bus.i_address;
                    mem_we_d      = 4'b0000;
                    mem_re_d      = 1'b1;
                end
            end
            D_BUSY, I_BUSY: begin
                if (done) begin
                    state_d  = IDLE;
                    mem_we_d = 4'b0000;
                    mem_re_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is returned in the ack/timeout cycle; suppressed during reset
    assign d_sel = (state_q == D_BUSY) & ~reset;
    assign i_sel = (state_q == I_BUSY) & ~reset;

    assign bus.d_ready = d_sel & done;
    assign bus.d_error = d_sel & timeout;
    assign bus.d_rdata = (d_sel & bus.mem_ack) ? bus.mem_rdata : 32'h0;
    assign bus.i_ready = i_sel & done;
    assign bus.i_error = i_sel & timeout;
    assign bus.i_rdata = (i_sel & bus.mem_ack) ? bus.mem_rdata : 32'h0;

    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_re      = mem_re_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, byte writes, round-robin,
// watchdog abort, ack/timeout boundary and reset during an access.
module tb_mem_port_arbiter;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; inputs are then driven 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.d_read    = 1'b0;
        bus.d_write   = 4'b0000;
        bus.d_address = 30'h0;
        bus.d_wdata   = 32'h0;
        bus.i_read    = 1'b0;
        bus.i_address = 30'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bus.mem_address, bus.mem_wdata, bus.mem_we, bus.mem_re} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%h wdata=%h we=%b re=%b required all 0",
                     bus.mem_address, bus.mem_wdata, bus.mem_we, bus.mem_re);
        end
        n_tests++;
        if ({bus.d_rdata, bus.d_ready, bus.d_error, bus.i_rdata, bus.i_ready, bus.i_error} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_req: got d_rdata=%h d_ready=%b i_rdata=%h i_ready=%b required all 0",
                     bus.d_rdata, bus.d_ready, bus.i_rdata, bus.i_ready);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_data_read();
        bus.d_read    = 1'b1;
        bus.d_address = 30'h0000100;
        #1;
        n_tests++;
        if (bus.mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle_re: got %b required 0", bus.mem_re);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end
            #1;
            n_tests++;
            if (bus.mem_re !== 1'b1 || bus.mem_we !== 4'b0000 || bus.mem_address !== 30'h0000100) begin
                n_fail++;
                $display("FAIL read_strobe%0d: got re=%b we=%b addr=%h required re=1 we=0000 addr=0000100",
                         c, bus.mem_re, bus.mem_we, bus.mem_address);
            end
            n_tests++;
            if (bus.d_ready !== (c == 2) || bus.i_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL read_ready%0d: got d_ready=%b i_ready=%b required d_ready=%b i_ready=0",
                         c, bus.d_ready, bus.i_ready, (c == 2));
            end
            if (c < 2) tick();
        end
        n_tests++;
        if (bus.d_rdata !== 32'hDEADBEEF || bus.d_error !== 1'b0 || bus.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL read_data: got d_rdata=%h d_error=%b i_rdata=%h required DEADBEEF 0 00000000",
                     bus.d_rdata, bus.d_error, bus.i_rdata);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.mem_re !== 1'b0 || bus.d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after: got re=%b d_ready=%b required 0 0", bus.mem_re, bus.d_ready);
        end
        tick();
    endtask

    task automatic test_byte_write();
        bus.d_read    = 1'b1;
        bus.d_write   = 4'b0011;
        bus.d_wdata   = 32'h12345678;
        bus.d_address = 30'h000002A;
        tick();
        n_tests++;
        if (bus.mem_we !== 4'b0011 || bus.mem_re !== 1'b0 || bus.mem_wdata !== 32'h12345678
            || bus.mem_address !== 30'h000002A) begin
            n_fail++;
            $display("FAIL write_strobe: got we=%b re=%b wdata=%h addr=%h required 0011 0 12345678 000002A",
                     bus.mem_we, bus.mem_re, bus.mem_wdata, bus.mem_address);
        end
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.d_ready !== 1'b1 || bus.d_error !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ready: got d_ready=%b d_error=%b required 1 0", bus.d_ready, bus.d_error);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.mem_we !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_clear: got we=%b required 0000", bus.mem_we);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [7:0] exp_d;
        logic [7:0] exp_i;
        exp_d = 8'h22;
        exp_i = 8'h88;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.d_read    = 1'b1;
        bus.d_address = 30'h0000010;
        bus.i_read    = 1'b1;
        bus.i_address = 30'h0000020;
        bus.mem_ack   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.mem_rdata = 32'hA0000000 + 32'(c);
            #1;
            n_tests++;
            if (bus.d_ready !== exp_d[c] || bus.i_ready !== exp_i[c]) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: got d_ready=%b i_ready=%b required %b %b",
                         c, bus.d_ready, bus.i_ready, exp_d[c], exp_i[c]);
            end
            n_tests++;
            if (bus.d_rdata !== (exp_d[c] ? bus.mem_rdata : 32'h0)
                || bus.i_rdata !== (exp_i[c] ? bus.mem_rdata : 32'h0)) begin
                n_fail++;
                $display("FAIL rr_data%0d: got d_rdata=%h i_rdata=%h", c, bus.d_rdata, bus.i_rdata);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        bus.i_read    = 1'b1;
        bus.i_address = 30'h0000333;
        bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_tests++;
            if (bus.mem_re !== 1'b1 || bus.i_ready !== (c == 4) || bus.i_error !== (c == 4)
                || bus.d_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_c%0d: got re=%b i_ready=%b i_error=%b d_ready=%b required 1 %b %b 0",
                         c, bus.mem_re, bus.i_ready, bus.i_error, bus.d_ready, (c == 4), (c == 4));
            end
            if (c < 4) tick();
        end
        n_tests++;
        if (bus.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_rdata: got %h required 00000000", bus.i_rdata);
        end
        tick();
        bus.i_read = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_re !== 1'b0 || bus.i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: got re=%b i_ready=%b required 0 0", bus.mem_re, bus.i_ready);
        end
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: got i_ready=%b d_ready=%b required 0 0", bus.i_ready, bus.d_ready);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_ack_boundary();
        bus.d_read    = 1'b1;
        bus.d_address = 30'h0000005;
        tick();
        tick();
        tick();
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        n_tests++;
        if (bus.d_ready !== 1'b1 || bus.d_error !== 1'b0 || bus.d_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL ack_boundary: got ready=%b error=%b rdata=%h required 1 0 CAFEF00D",
                     bus.d_ready, bus.d_error, bus.d_rdata);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.d_read    = 1'b1;
        bus.d_address = 30'h0000077;
        tick();
        n_tests++;
        if (bus.mem_re !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got re=%b required 1", bus.mem_re);
        end
        reset       = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b required 0", bus.d_ready);
        end
        tick();
        #1;
        n_tests++;
        if ({bus.mem_address, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.d_ready, bus.i_ready} !== 69'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got addr=%h we=%b re=%b d_ready=%b required all 0",
                     bus.mem_address, bus.mem_we, bus.mem_re, bus.d_ready);
        end
        reset         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.d_address = 30'h0000011;
        bus.i_read    = 1'b1;
        bus.i_address = 30'h0000022;
        tick();
        n_tests++;
        if (bus.mem_re !== 1'b1 || bus.mem_address !== 30'h0000011) begin
            n_fail++;
            $display("FAIL rst_tie_grant: got re=%b addr=%h required 1 0000011",
                     bus.mem_re, bus.mem_address);
        end
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tie_ready: got d_ready=%b i_ready=%b required 1 0", bus.d_ready, bus.i_ready);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();
        test_reset();
        test_data_read();
        test_byte_write();
        test_contention();
        test_timeout();
        test_ack_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
